// File: rtl/sram_arbiter_if.sv
// Bus bundle between the three SRAM masters, the arbiter and the SRAM controller.
// The slave modport is the arbiter's view; the master modport drives requests and target responses.
interface sram_arbiter_if #(
   parameter int AW = 18
);
   logic [3*AW-1:0] m_addr;
   logic [2:0]      m_rd;
   logic [2:0]      m_wr;
   logic [95:0]     m_wdata;
   logic [11:0]     m_be;
   logic [2:0]      m_wait;
   logic [31:0]     m_rddata;
   logic [2:0]      m_rdvalid;

   logic [AW-1:0]   t_addr;
   logic            t_rd;
   logic            t_wr;
   logic [31:0]     t_wdata;
   logic [3:0]      t_be;
   logic            t_wait;
   logic [31:0]     t_rddata;
   logic            t_rdvalid;

   modport slave (
      input  m_addr, m_rd, m_wr, m_wdata, m_be,
      input  t_wait, t_rddata, t_rdvalid,
      output m_wait, m_rddata, m_rdvalid,
      output t_addr, t_rd, t_wr, t_wdata, t_be
   );

   modport master (
      output m_addr, m_rd, m_wr, m_wdata, m_be,
      output t_wait, t_rddata, t_rdvalid,
      input  m_wait, m_rddata, m_rdvalid,
      input  t_addr, t_rd, t_wr, t_wdata, t_be
   );
endinterface

// File: rtl/sram_arbiter.sv
// Three-master SRAM port arbiter: m0 (VGA) priority with starvation relief, m1/m2 round-robin,
// and an in-order tag FIFO that steers read returns back to the issuing master.
module sram_arbiter #(
   parameter int AW         = 18,
   parameter int TAG_DEPTH  = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic          clock,
   input  logic          rst,
   sram_arbiter_if.slave bus,
   output logic          err_orphan
);

   localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
   localparam logic [PW:0]   FULL_CNT   = (PW + 1)'(TAG_DEPTH);

   logic [2:0]    req;
   logic [2:0]    rd_eff;
   logic [2:0]    rd_block;
   logic [2:0]    grant;
   logic [1:0]    gidx;
   logic          g_rd;
   logic          g_wr;
   logic          g_block;
   logic          accept;
   logic          push;
   logic          pop;
   logic          full;
   logic          empty;
   logic [1:0]    head;

   logic [1:0]    tag_mem [TAG_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count;
   logic [SW-1:0] starve_cnt;
   logic          rr_m2;

   assign req    = bus.m_rd | bus.m_wr;
   // A simultaneous read+write is treated as a write, so it never needs a tag.
   assign rd_eff = bus.m_rd & ~bus.m_wr;
   assign full   = (count == FULL_CNT);
   assign empty  = (count == '0);
   assign rd_block = rd_eff & {3{full & ~bus.t_rdvalid}};

   always_comb begin
      grant = 3'b000;
      if (req[0] && (starve_cnt < STARVE_LIM))
         grant = 3'b001;
      else if (!rr_m2 && req[1])
         grant = 3'b010;
      else if (rr_m2 && req[2])
         grant = 3'b100;
      else if (req[1])
         grant = 3'b010;
      else if (req[2])
         grant = 3'b100;
      else if (req[0])
         grant = 3'b001;
   end

   always_comb begin
      gidx = 2'd0;
      if (grant[1])
         gidx = 2'd1;
      else if (grant[2])
         gidx = 2'd2;
   end

   always_comb begin
      bus.t_addr  = bus.m_addr[0 +: AW];
      bus.t_wdata = bus.m_wdata[0 +: 32];
      bus.t_be    = bus.m_be[0 +: 4];
      case (gidx)
         2'd1: begin
            bus.t_addr  = bus.m_addr[AW +: AW];
            bus.t_wdata = bus.m_wdata[32 +: 32];
            bus.t_be    = bus.m_be[4 +: 4];
         end
         2'd2: begin
            bus.t_addr  = bus.m_addr[2*AW +: AW];
            bus.t_wdata = bus.m_wdata[64 +: 32];
            bus.t_be    = bus.m_be[8 +: 4];
         end
         default: ;
      endcase
   end

   assign g_rd    = |(grant & rd_eff);
   assign g_wr    = |(grant & bus.m_wr);
   assign g_block = |(grant & rd_block);

   assign bus.t_rd = g_rd & ~g_block & ~rst;
   assign bus.t_wr = g_wr & ~rst;
   assign accept   = (bus.t_rd | bus.t_wr) & ~bus.t_wait;
   assign push     = bus.t_rd & ~bus.t_wait;
   assign pop      = bus.t_rdvalid & ~empty & ~rst;

   assign bus.m_wait = rst ? req : (req & ~(grant & {3{~bus.t_wait}} & ~rd_block));

   assign head          = tag_mem[rd_ptr];
   assign bus.m_rddata  = bus.t_rddata;
   assign bus.m_rdvalid = (3'b001 << head) & {3{pop}};

   always_ff @(posedge clock) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         starve_cnt <= '0;
         rr_m2      <= 1'b0;
         err_orphan <= 1'b0;
      end else begin
         if (push) begin
            tag_mem[wr_ptr] <= gidx;
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase

         if (bus.t_rdvalid && empty)
            err_orphan <= 1'b1;

         // Starvation count only matters while m1/m2 are actually waiting.
         if (!(req[1] || req[2])) begin
            starve_cnt <= '0;
         end else if (accept) begin
            if (grant[0]) begin
               if (starve_cnt != STARVE_LIM)
                  starve_cnt <= starve_cnt + 1'b1;
            end else begin
               starve_cnt <= '0;
               rr_m2      <= grant[1];
            end
         end
      end
   end

endmodule
